// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game datapath: playback FSM states,
// sequence sizing and the four color codes.
package simon_pkg;

    localparam int SEQ_LEN_MAX = 32;
    localparam int COLOR_W     = 2;

    localparam logic [1:0] COLOR_GREEN  = 2'd0;
    localparam logic [1:0] COLOR_RED    = 2'd1;
    localparam logic [1:0] COLOR_BLUE   = 2'd2;
    localparam logic [1:0] COLOR_YELLOW = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SHOW_ARM = 3'd2,
        SHOW     = 3'd3,
        GAP_ARM  = 3'd4,
        GAP      = 3'd5,
        FIN      = 3'd6
    } play_state_e;

endpackage

// File: rtl/simon_playback_color_decode.sv
// 2-to-4 one-hot decoder from a stored color code to an LED/button lane.
// Shared by the playback path and the input-compare stage.
module color_decode
    import simon_pkg::*;
(
    input  logic [1:0] code,
    output logic [3:0] onehot
);

    // Map each color code to exactly one lane
    always_comb begin
        onehot = 4'b0000;
        case (code)
            COLOR_GREEN:  onehot = 4'b0001;
            COLOR_RED:    onehot = 4'b0010;
            COLOR_BLUE:   onehot = 4'b0100;
            COLOR_YELLOW: onehot = 4'b1000;
            default:      onehot = 4'b0000;
        endcase
    end

endmodule

// File: rtl/simon_playback.sv
// Plays the stored Simon color sequence on the LEDs, pacing each lit step
// and each inter-step gap with one expiry of the external delay timer.
module simon_playback
    import simon_pkg::*;
#(
    parameter int SEQ_LEN_MAX_P = SEQ_LEN_MAX,
    parameter int COLOR_W_P     = COLOR_W,
    localparam int ADDR_W       = $clog2(SEQ_LEN_MAX_P),
    localparam int LEN_W        = ADDR_W + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 play,
    input  logic [LEN_W-1:0]     seq_len,
    output logic [ADDR_W-1:0]    seq_rd_addr,
    input  logic [COLOR_W_P-1:0] seq_rd_data,
    output logic                 timer_start,
    input  logic                 timer_times_up,
    output logic [3:0]           led,
    output logic                 busy,
    output logic                 done
);

    play_state_e          state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [COLOR_W_P-1:0] color_q, color_d;
    logic [3:0]           led_q, led_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [LEN_W-1:0]     len_clamp_s;
    logic [3:0]           color_onehot_s;

    color_decode u_color_decode (
        .code   (color_q[1:0]),
        .onehot (color_onehot_s)
    );

    // Clamp the requested length to the RAM depth
    always_comb begin
        len_clamp_s = seq_len;
        if (seq_len > LEN_W'(SEQ_LEN_MAX_P)) begin
            len_clamp_s = LEN_W'(SEQ_LEN_MAX_P);
        end else begin
            len_clamp_s = seq_len;
        end
    end

    // Next-state and next-output logic; start is only re-armed after the
    // timer has reported times_up = 1 again, so every arm state waits on it.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        color_d = color_q;
        led_d   = led_q;
        start_d = start_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                led_d   = 4'b0000;
                start_d = 1'b0;
                if (play) begin
                    len_d   = len_clamp_s;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (len_clamp_s == '0) ? FIN : LOAD;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            LOAD: begin
                color_d = seq_rd_data;
                state_d = SHOW_ARM;
            end
            SHOW_ARM: begin
                if (timer_times_up) begin
                    start_d = 1'b1;
                    led_d   = color_onehot_s;
                    state_d = SHOW;
                end else begin
                    start_d = 1'b0;
                    state_d = SHOW_ARM;
                end
            end
            SHOW: begin
                if (!timer_times_up) begin
                    led_d   = 4'b0000;
                    start_d = 1'b0;
                    state_d = GAP_ARM;
                end else begin
                    state_d = SHOW;
                end
            end
            GAP_ARM: begin
                if (timer_times_up) begin
                    start_d = 1'b1;
                    state_d = GAP;
                end else begin
                    start_d = 1'b0;
                    state_d = GAP_ARM;
                end
            end
            GAP: begin
                if (!timer_times_up) begin
                    start_d = 1'b0;
                    if ({1'b0, idx_q} == (len_q - LEN_W'(1))) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = LOAD;
                    end
                end else begin
                    state_d = GAP;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                led_d   = 4'b0000;
                start_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                led_d   = 4'b0000;
                start_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            color_q <= '0;
            led_q   <= 4'b0000;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            color_q <= color_d;
            led_q   <= led_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign seq_rd_addr = idx_q;
    assign timer_start = start_q;
    assign led         = led_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_simon_playback.sv
// Bench for simon_playback: short delay-timer model, sequence RAM, and a
// step-level reference built from the stored colors.
module tb_simon_playback;

    localparam int TMR_CYC = 4;
    localparam int EXP_LIT = TMR_CYC + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       play;
    logic [5:0] seq_len;
    logic [4:0] seq_rd_addr;
    logic [1:0] seq_rd_data;
    logic       timer_start;
    logic       tu;
    logic [3:0] led;
    logic       busy;
    logic       done;

    logic [1:0] ram [32];
    assign seq_rd_data = ram[seq_rd_addr];

    simon_playback dut (
        .clock          (clock),
        .reset          (reset),
        .play           (play),
        .seq_len        (seq_len),
        .seq_rd_addr    (seq_rd_addr),
        .seq_rd_data    (seq_rd_data),
        .timer_start    (timer_start),
        .timer_times_up (tu),
        .led            (led),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;

    // Delay timer model: expires after TMR_CYC sampled starts, optional hold
    int tcnt, hcnt, hold_extra;
    always @(posedge clock) begin
        if (reset) begin
            tcnt <= 0; hcnt <= 0; tu <= 1'b1;
        end else if (timer_start) begin
            if (tcnt < TMR_CYC) tcnt <= tcnt + 1;
            if (tcnt + 1 >= TMR_CYC) begin tu <= 1'b0; hcnt <= hold_extra; end
        end else if (hcnt > 0) begin
            hcnt <= hcnt - 1;
        end else begin
            tcnt <= 0; tu <= 1'b1;
        end
    end

    // Monitor: collects lit steps, pulse counts and protocol violations
    int         cyc = 0;
    int         viol, done_cnt, done_cyc, first_lit, start_cnt, bad_len, max_addr, cur_len;
    logic [3:0] lit_q[$];
    logic       prev_start = 1'b0, prev_tu = 1'b1;
    logic [3:0] prev_led = 4'b0000;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (led != 4'b0000 && !$onehot(led)) viol++;
        if (led != 4'b0000 && !(timer_start && busy)) viol++;
        if (timer_start) start_cnt++;
        if (timer_start && !prev_start && prev_tu !== 1'b1) viol++;
        if (led != 4'b0000 && prev_led == 4'b0000) begin
            lit_q.push_back(led);
            if (first_lit < 0) first_lit = cyc;
            if (!(timer_start && !prev_start)) viol++;
            cur_len = 1;
        end else if (led != 4'b0000) begin
            cur_len++;
        end
        if (led == 4'b0000 && prev_led != 4'b0000 && !reset && cur_len != EXP_LIT) bad_len++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (int'(seq_rd_addr) > max_addr) max_addr = int'(seq_rd_addr);
        prev_start = timer_start; prev_tu = tu; prev_led = led;
    end

    int n_cmp = 0, n_fail = 0;
    int play_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(negedge clock); #1; end
    endtask

    task automatic clear_mon();
        viol = 0; done_cnt = 0; done_cyc = -1; first_lit = -1; start_cnt = 0;
        bad_len = 0; max_addr = 0; cur_len = 0; lit_q.delete();
    endtask

    task automatic do_play(input logic [5:0] len);
        @(posedge clock); #1;
        clear_mon();
        play = 1'b1; seq_len = len; play_cyc = cyc + 1;
        @(posedge clock); #1;
        play = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin tick(1); n++; end
        check("done_seen", (n < limit), 1);
        tick(1);
        check("busy_after_done", busy, 0);
        tick(4);
        check("single_done", done_cnt, 1);
    endtask

    task automatic check_steps(input string tag, input int n);
        logic [3:0] one = 4'b0001;
        check({tag, "_count"}, lit_q.size(), n);
        for (int i = 0; i < n && i < lit_q.size(); i++)
            check({tag, "_color"}, lit_q[i], one << ram[i]);
        check({tag, "_proto"}, viol, 0);
        check({tag, "_litlen"}, bad_len, 0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) ram[i] = 2'($urandom_range(0, 3));
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; seq_len = 6'd0; hold_extra = 0;
        fill_random();
        clear_mon();
        tick(3);
        check("rst_led", led, 0);
        check("rst_start", timer_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", seq_rd_addr, 0);
        @(posedge clock); #1; reset = 1'b0;
        tick(2);

        // Directed three-step sequence
        ram[0] = 2'd2; ram[1] = 2'd0; ram[2] = 2'd3;
        do_play(6'd3);
        tick(1);
        check("busy_on_play", busy, 1);
        wait_done(300);
        check_steps("seq3", 3);
        check("led_latency", first_lit - play_cyc, 3);

        // Empty sequence
        do_play(6'd0);
        wait_done(20);
        check("len0_leds", lit_q.size(), 0);
        check("len0_start", start_cnt, 0);
        check("len0_done_lat", done_cyc - play_cyc, 2);

        // Over-length request is clamped
        fill_random();
        do_play(6'd40);
        wait_done(2000);
        check_steps("len40", 32);
        check("len40_maxaddr", max_addr, 31);

        // Replay request during step 2 is ignored
        fill_random();
        do_play(6'd5);
        for (int n = 0; lit_q.size() < 2 && n < 200; n++) tick(1);
        check("reach_step2", lit_q.size(), 2);
        @(posedge clock); #1; play = 1'b1; seq_len = 6'd7;
        @(posedge clock); #1; play = 1'b0;
        wait_done(400);
        check_steps("replay_ign", 5);

        // Reset mid-SHOW, with a simultaneous play, then restart
        fill_random();
        do_play(6'd4);
        for (int n = 0; lit_q.size() < 1 && n < 100; n++) tick(1);
        check("reach_show", lit_q.size(), 1);
        tick(2);
        @(posedge clock); #1; reset = 1'b1; play = 1'b1; seq_len = 6'd3;
        @(posedge clock); #1; reset = 1'b0; play = 1'b0;
        tick(0);
        @(negedge clock); #1;
        check("abort_led", led, 0);
        check("abort_start", timer_start, 0);
        check("abort_busy", busy, 0);
        tick(6);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 0);
        do_play(6'd2);
        wait_done(300);
        check_steps("restart", 2);
        check("restart_maxaddr", max_addr, 1);

        // Slow timer recovery: arm states must wait for times_up = 1
        fill_random();
        hold_extra = 3;
        do_play(6'd3);
        wait_done(500);
        check_steps("slow_tmr", 3);
        hold_extra = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
